// File: rtl/latch_pkg.sv
// Shared definitions for the latch write sequencer: FSM state encoding,
// the minimum phase length, and the zero-to-one clamp for timing fields.
package latch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_SETUP = 3'd2,
        ST_OPEN  = 3'd3,
        ST_HOLD  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam int MIN_PHASE = 1;
    localparam int PHASE_W   = 16;

    // A programmed length of zero would skip a phase entirely, so it is
    // stretched to the minimum phase length instead.
    function automatic logic [PHASE_W-1:0] clamp_phase(input logic [PHASE_W-1:0] len);
        logic [PHASE_W-1:0] res;
        if (len < PHASE_W'(MIN_PHASE)) begin
            res = PHASE_W'(MIN_PHASE);
        end else begin
            res = len;
        end
        return res;
    endfunction

endpackage

// File: rtl/latch_phase_counter.sv
// Loadable down-counter shared by the setup, open and hold phases.
// It saturates at zero, so Zero stays asserted until the next load.
module latch_phase_counter #(
    parameter int CNT_W = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Load,
    input  logic [CNT_W-1:0] Load_Val,
    output logic             Zero
);

    logic [CNT_W-1:0] count_r;

    // Count register: load, or step down towards zero and stop there.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (Load) begin
            count_r <= Load_Val;
        end else if (count_r != {CNT_W{1'b0}}) begin
            count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign Zero = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/latch_write_sequencer.sv
// Initiator for a transparent D-latch bank: sequences D setup, gate-open and
// hold intervals so the latch never sees D change while its gate is high.
module latch_write_sequencer
    import latch_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [WIDTH-1:0] In_Data,
    input  logic [CNT_W-1:0] Setup_Cycles,
    input  logic [CNT_W-1:0] Open_Cycles,
    input  logic [CNT_W-1:0] Hold_Cycles,
    input  logic             Clear_Req,
    output logic [WIDTH-1:0] Latch_D,
    output logic             Latch_Gate,
    output logic             Latch_Clr,
    output logic             Busy,
    output logic             Done
);

    state_t           state_r;
    state_t           state_next_s;
    logic             accept_s;
    logic             cnt_load_s;
    logic [CNT_W-1:0] cnt_load_val_s;
    logic             cnt_zero_s;
    logic [CNT_W-1:0] setup_m1_s;
    logic [CNT_W-1:0] open_m1_s;
    logic [CNT_W-1:0] hold_m1_s;
    logic [CNT_W-1:0] open_m1_r;
    logic [CNT_W-1:0] hold_m1_r;
    logic             ready_r;

    // Clamped phase lengths minus one, i.e. the counter load values.
    always_comb begin
        setup_m1_s = CNT_W'(clamp_phase(PHASE_W'(Setup_Cycles)) - PHASE_W'(1));
        open_m1_s  = CNT_W'(clamp_phase(PHASE_W'(Open_Cycles)) - PHASE_W'(1));
        hold_m1_s  = CNT_W'(clamp_phase(PHASE_W'(Hold_Cycles)) - PHASE_W'(1));
    end

    latch_phase_counter #(
        .CNT_W (CNT_W)
    ) u_phase_counter (
        .Clock    (Clock),
        .Reset    (Reset),
        .Load     (cnt_load_s),
        .Load_Val (cnt_load_val_s),
        .Zero     (cnt_zero_s)
    );

    // Next-state logic; each phase exit reloads the counter for the next one.
    always_comb begin
        state_next_s   = state_r;
        accept_s       = 1'b0;
        cnt_load_s     = 1'b0;
        cnt_load_val_s = {CNT_W{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (Clear_Req) begin
                    state_next_s = ST_CLEAR;
                end else if (In_Valid) begin
                    state_next_s   = ST_SETUP;
                    accept_s       = 1'b1;
                    cnt_load_s     = 1'b1;
                    cnt_load_val_s = setup_m1_s;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                state_next_s = ST_IDLE;
            end
            ST_SETUP: begin
                if (cnt_zero_s) begin
                    state_next_s   = ST_OPEN;
                    cnt_load_s     = 1'b1;
                    cnt_load_val_s = open_m1_r;
                end else begin
                    state_next_s = ST_SETUP;
                end
            end
            ST_OPEN: begin
                if (cnt_zero_s) begin
                    state_next_s   = ST_HOLD;
                    cnt_load_s     = 1'b1;
                    cnt_load_val_s = hold_m1_r;
                end else begin
                    state_next_s = ST_OPEN;
                end
            end
            ST_HOLD: begin
                if (cnt_zero_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; outputs decode the next state so they are
    // flop outputs aligned with the state they describe.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r    <= ST_IDLE;
            Latch_D    <= {WIDTH{1'b0}};
            Latch_Gate <= 1'b0;
            Latch_Clr  <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            ready_r    <= 1'b1;
            open_m1_r  <= {CNT_W{1'b0}};
            hold_m1_r  <= {CNT_W{1'b0}};
        end else begin
            state_r    <= state_next_s;
            Latch_Gate <= (state_next_s == ST_OPEN);
            Latch_Clr  <= (state_next_s == ST_CLEAR);
            Busy       <= (state_next_s != ST_IDLE);
            Done       <= (state_next_s == ST_DONE);
            ready_r    <= (state_next_s == ST_IDLE);
            if (accept_s) begin
                Latch_D   <= In_Data;
                open_m1_r <= open_m1_s;
                hold_m1_r <= hold_m1_s;
            end else if (state_next_s == ST_CLEAR) begin
                Latch_D   <= {WIDTH{1'b0}};
                open_m1_r <= open_m1_r;
                hold_m1_r <= hold_m1_r;
            end else begin
                Latch_D   <= Latch_D;
                open_m1_r <= open_m1_r;
                hold_m1_r <= hold_m1_r;
            end
        end
    end

    // Ready must drop in the very cycle Reset is raised, before any edge.
    assign In_Ready = ready_r & ~Reset;

endmodule

// File: tb/tb_latch_write_sequencer.sv
// Self-checking bench: a cycle-offset timeline model checked every cycle,
// plus directed writes with hand-computed gate/done/ready patterns.
module tb_latch_write_sequencer;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       In_Valid = 1'b0;
    logic       Clear_Req = 1'b0;
    logic [7:0] In_Data = 8'h00;
    logic [3:0] Setup_Cycles = 4'd0;
    logic [3:0] Open_Cycles = 4'd0;
    logic [3:0] Hold_Cycles = 4'd0;
    logic       In_Ready;
    logic [7:0] Latch_D;
    logic       Latch_Gate;
    logic       Latch_Clr;
    logic       Busy;
    logic       Done;

    int checks = 0;
    int errors = 0;

    latch_write_sequencer #(
        .WIDTH (8),
        .CNT_W (4)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .In_Valid     (In_Valid),
        .In_Ready     (In_Ready),
        .In_Data      (In_Data),
        .Setup_Cycles (Setup_Cycles),
        .Open_Cycles  (Open_Cycles),
        .Hold_Cycles  (Hold_Cycles),
        .Clear_Req    (Clear_Req),
        .Latch_D      (Latch_D),
        .Latch_Gate   (Latch_Gate),
        .Latch_Clr    (Latch_Clr),
        .Busy         (Busy),
        .Done         (Done)
    );

    always #5 Clock = ~Clock;

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_kind 0=idle, 1=clearing, 2=writing; a write is described only by
    // its accept edge and the three clamped lengths.
    int         n = 0;
    int         m_kind = 0;
    int         m_t0 = 0;
    int         m_s = 1;
    int         m_o = 1;
    int         m_h = 1;
    logic [7:0] m_d = 8'h00;
    bit         m_valid = 1'b0;

    initial begin
        forever begin
            @(posedge Clock);
            n++;
            if (Reset) begin
                m_kind  = 0;
                m_d     = 8'h00;
                m_valid = 1'b1;
            end else if (m_kind == 0) begin
                if (Clear_Req) begin
                    m_kind = 1;
                    m_d    = 8'h00;
                end else if (In_Valid) begin
                    m_kind = 2;
                    m_t0   = n;
                    m_s    = (Setup_Cycles == 4'd0) ? 1 : int'(Setup_Cycles);
                    m_o    = (Open_Cycles == 4'd0) ? 1 : int'(Open_Cycles);
                    m_h    = (Hold_Cycles == 4'd0) ? 1 : int'(Hold_Cycles);
                    m_d    = In_Data;
                end
            end else if (m_kind == 1) begin
                m_kind = 0;
            end else if (n - m_t0 == m_s + m_o + m_h + 1) begin
                m_kind = 0;
            end
        end
    end

    // Compare every cycle at the falling edge, where all outputs are settled.
    initial begin
        forever begin
            @(negedge Clock);
            if (m_valid) begin : cmp
                int   k;
                logic eg;
                logic ed;
                k  = n - m_t0;
                eg = (m_kind == 2) && (k >= m_s) && (k < m_s + m_o);
                ed = (m_kind == 2) && (k == m_s + m_o + m_h);
                check8("model_d", Latch_D, m_d);
                check1("model_gate", Latch_Gate, eg);
                check1("model_done", Done, ed);
                check1("model_clr", Latch_Clr, m_kind == 1);
                check1("model_busy", Busy, m_kind != 0);
                check1("model_ready", In_Ready, (m_kind == 0) && !Reset);
            end
        end
    end

    task automatic cyc();
        @(posedge Clock);
        #2;
    endtask

    logic [7:0] g;
    logic [7:0] dn;
    logic [7:0] rd;

    initial begin
        // Reset held for two edges.
        cyc();
        cyc();
        check1("rst_ready", In_Ready, 1'b0);
        check1("rst_gate", Latch_Gate, 1'b0);
        check8("rst_d", Latch_D, 8'h00);
        check1("rst_busy", Busy, 1'b0);
        Reset = 1'b0;
        cyc();
        check1("rel_ready", In_Ready, 1'b1);

        // S=2 O=3 H=1 write of A5: offsets counted from the cycle after accept.
        In_Data = 8'hA5; Setup_Cycles = 4'd2; Open_Cycles = 4'd3; Hold_Cycles = 4'd1;
        In_Valid = 1'b1;
        cyc();
        In_Valid = 1'b0;
        check8("wr1_d", Latch_D, 8'hA5);
        g = 8'h00; dn = 8'h00; rd = 8'h00;
        for (int k = 0; k < 8; k++) begin
            g[k] = Latch_Gate; dn[k] = Done; rd[k] = In_Ready;
            cyc();
        end
        check8("wr1_gate", g, 8'h1C);
        check8("wr1_done", dn, 8'h40);
        check8("wr1_ready", rd, 8'h80);

        // Zero fields behave as one each.
        In_Data = 8'h5A; Setup_Cycles = 4'd0; Open_Cycles = 4'd0; Hold_Cycles = 4'd0;
        In_Valid = 1'b1;
        cyc();
        In_Valid = 1'b0;
        g = 8'h00; dn = 8'h00; rd = 8'h00;
        for (int k = 0; k < 6; k++) begin
            g[k] = Latch_Gate; dn[k] = Done; rd[k] = In_Ready;
            cyc();
        end
        check8("wr0_gate", g, 8'h02);
        check8("wr0_done", dn, 8'h08);
        check8("wr0_ready", rd, 8'h30);

        // Clear beats a simultaneous write; the held write follows.
        In_Data = 8'h3C; Setup_Cycles = 4'd1; Open_Cycles = 4'd1; Hold_Cycles = 4'd1;
        Clear_Req = 1'b1; In_Valid = 1'b1;
        cyc();
        Clear_Req = 1'b0;
        check1("clr_pulse", Latch_Clr, 1'b1);
        check8("clr_d", Latch_D, 8'h00);
        check1("clr_ready", In_Ready, 1'b0);
        cyc();
        check1("clr_end", Latch_Clr, 1'b0);
        check1("clr_idle_ready", In_Ready, 1'b1);
        cyc();
        In_Valid = 1'b0;
        check8("clr_wr_d", Latch_D, 8'h3C);
        for (int k = 0; k < 4; k++) cyc();
        check1("clr_wr_ready", In_Ready, 1'b1);

        // Input changes during OPEN must not disturb D or the gate width.
        In_Data = 8'h11; Setup_Cycles = 4'd1; Open_Cycles = 4'd2; Hold_Cycles = 4'd1;
        In_Valid = 1'b1;
        cyc();
        In_Valid = 1'b0;
        cyc();
        In_Data = 8'hFF; Open_Cycles = 4'd5;
        g = 8'h00; dn = 8'h00;
        for (int k = 0; k < 5; k++) begin
            g[k] = Latch_Gate; dn[k] = Done;
            check8("mid_d", Latch_D, 8'h11);
            cyc();
        end
        check8("mid_gate", g, 8'h03);
        check8("mid_done", dn, 8'h08);

        // Reset while the gate is open abandons the write.
        In_Data = 8'h77; Setup_Cycles = 4'd1; Open_Cycles = 4'd3; Hold_Cycles = 4'd1;
        In_Valid = 1'b1;
        cyc();
        In_Valid = 1'b0;
        cyc();
        check1("abort_gate_open", Latch_Gate, 1'b1);
        Reset = 1'b1;
        #1;
        check1("abort_gate_held", Latch_Gate, 1'b1);
        check1("abort_ready_rst", In_Ready, 1'b0);
        cyc();
        check1("abort_gate", Latch_Gate, 1'b0);
        check8("abort_d", Latch_D, 8'h00);
        check1("abort_busy", Busy, 1'b0);
        check1("abort_done", Done, 1'b0);
        Reset = 1'b0;
        #1;
        check1("abort_ready", In_Ready, 1'b1);
        dn = 8'h00;
        for (int k = 0; k < 6; k++) begin
            dn[k] = Done;
            cyc();
        end
        check8("abort_no_done", dn, 8'h00);

        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/latch_write_sequencer.md
Name: latch_write_sequencer

Overview:
- Initiator side of the transparent D-latch write interface.
- Accepts a data word over a valid/ready handshake and drives a latch bank's D, Gate and Clear lines.
- Uses programmable setup, gate-open and hold intervals, so the level-sensitive latch captures cleanly and never sees D change while Gate is high.
- Sits between the register-file write logic and the latch array; all outputs are registered and glitch-free.

Parameters:
- WIDTH, 8, data width of In_Data and Latch_D.
- CNT_W, 4, width of the timing fields and the phase counter.

Ports:
- Clock  input  1  system clock; all state updates on posedge.
- Reset  input  1  synchronous, active-high reset.
- In_Valid  input  1  write request valid.
- In_Ready  output  1  sequencer can accept a request; high only in IDLE.
- In_Data  input  WIDTH  word to write.
- Setup_Cycles  input  CNT_W  cycles D is stable before Gate rises; sampled at accept.
- Open_Cycles  input  CNT_W  cycles Gate is held high; sampled at accept.
- Hold_Cycles  input  CNT_W  cycles D is held after Gate falls; sampled at accept.
- Clear_Req  input  1  request a latch clear; sampled only in IDLE.
- Latch_D  output  WIDTH  data to the latch D inputs.
- Latch_Gate  output  1  latch transparent enable.
- Latch_Clr  output  1  latch clear, one-cycle pulse.
- Busy  output  1  high in any state other than IDLE.
- Done  output  1  one-cycle pulse when a write completes.

Behaviour:
- Reset: state IDLE; Latch_D=0, Latch_Gate=0, Latch_Clr=0, Done=0, Busy=0, counter=0.
- Reset: In_Ready=0 in any cycle where Reset=1.
- States: IDLE, CLEAR, SETUP, OPEN, HOLD, DONE.
- IDLE: In_Ready=1, Gate=0, Latch_D keeps its last value. The latch is opaque, so D changes there are harmless; D still does not toggle.
- IDLE, Clear_Req=1: go to CLEAR. Clear_Req has priority over In_Valid; the request is not accepted and In_Valid must be held.
- CLEAR: Latch_Clr=1, Latch_D<=0 for exactly 1 cycle, then IDLE.
- IDLE, In_Valid=1, Clear_Req=0: accept.
  - Latch_D<=In_Data.
  - Load the three timing fields; a value of 0 is treated as 1.
  - Counter<=S-1; go to SETUP.
- SETUP: Gate=0 for S cycles, then OPEN with counter<=O-1.
- OPEN: Gate=1 for O cycles, then HOLD with counter<=H-1.
- HOLD: Gate=0, Latch_D unchanged for H cycles, then DONE.
- DONE: Done=1 for 1 cycle, then IDLE.
- Timing: accept at edge t0. Gate is high in cycles t0+S+1 .. t0+S+O. Done is high in cycle t0+S+O+H+1. In_Ready returns at t0+S+O+H+2.
- Latch_D is constant from accept through the end of HOLD. Gate rises and falls only on state transitions, so it never changes in the same cycle as Latch_D.
- In_Valid, Clear_Req and timing inputs are ignored outside IDLE; timing-field changes mid-transaction have no effect.
- Back-to-back writes: minimum spacing is S+O+H+2 cycles.
- Counter arithmetic: unsigned CNT_W-bit down-counter; the phase ends when counter==0. No wrap, because the load is always ≥0.
- Reset mid-operation: at the next edge Gate=0, Latch_D=0, Latch_Clr=0, state IDLE, no Done pulse. The partial write is abandoned.

Decomposition:
- Shared package latch_pkg:
  - state encoding localparams: ST_IDLE, ST_CLEAR, ST_SETUP, ST_OPEN, ST_HOLD, ST_DONE;
  - MIN_PHASE=1;
  - the zero-to-one clamp function.
- Sub-module latch_phase_counter(Clock, Reset, Load, Load_Val[CNT_W], Zero):
  - a loadable down-counter;
  - instantiated once and reused for all three phases.

Test Plan:
- Reset=1 for 2 cycles → In_Ready=0, Gate=0, Latch_D=0, Busy=0. After release, In_Ready=1 on the next cycle.
- Write In_Data=8'hA5 with S=2, O=3, H=1 → Latch_D=A5 from t0+1. Gate=1 exactly in t0+3..t0+5. Done at t0+7. In_Ready=1 at t0+8.
- Write with S=O=H=0 → treated as 1 each. Gate high only in t0+2; Done at t0+4.
- Clear_Req=1 and In_Valid=1 (data 8'h3C) in the same IDLE cycle → one Latch_Clr pulse with Latch_D=0, then the write of 3C proceeds after returning to IDLE.
- Change In_Data to 8'hFF and Open_Cycles to 5 during OPEN of an O=2 write of 8'h11 → Latch_D stays 11 and Gate is high for 2 cycles only.
- Assert Reset while Gate=1 during a write → Gate=0 and Latch_D=0 at the next edge. No Done pulse; In_Ready=1 after Reset deasserts.
